// File: rtl/rbf_layer_accum_serial.sv
// Serial-to-parallel accumulator behind the RBF activation block.
// Collects LSB-first N-bit two's-complement words from the (y_in, fbit_in)
// stream, sums M of them, and publishes the full-width and saturated sums
// with a one-cycle valid pulse.
module rbf_layer_accum_serial #(
    parameter int N     = 16,
    parameter int M     = 4,
    parameter int CNT_W = $clog2(M + 2),
    parameter int ACC_W = N + $clog2(M + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             y_in,
    input  logic             fbit_in,
    output logic [ACC_W-1:0] sum,
    output logic [N-1:0]     sum_sat,
    output logic             sum_valid,
    output logic             sat_flag,
    output logic             busy,
    output logic             frm_err
);

    localparam int BIT_W = $clog2(N + 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (N - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_ACC, ST_DONE} state_t;

    state_t                   state, state_next;
    logic [BIT_W-1:0]         bit_cnt;
    logic [N-1:0]             shreg;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sum;
    logic [CNT_W-1:0]         word_cnt;
    logic                     last_word;
    logic                     shift_en;
    logic                     start;
    logic                     acc_en;
    logic                     frame_bad;

    // Clip a full-precision sum into the signed N-bit range.
    function automatic logic [N-1:0] sat_word(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)
            return SAT_MAX[N-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[N-1:0];
        else
            return v[N-1:0];
    endfunction

    function automatic logic sat_hit(input logic signed [ACC_W-1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    // The completed word sits in shreg during ST_ACC; add it sign-extended.
    assign acc_sum   = acc + $signed({{(ACC_W - N){shreg[N-1]}}, shreg});
    assign last_word = (word_cnt == CNT_W'(M - 1));
    assign busy      = (state == ST_SHIFT) || (state == ST_ACC) || (word_cnt != '0);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Next-state and datapath strobes; clear overrides any frame start.
    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        start      = 1'b0;
        acc_en     = 1'b0;
        frame_bad  = 1'b0;
        if (clear) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (fbit_in) begin
                        shift_en   = 1'b1;
                        start      = 1'b1;
                        state_next = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shift_en = 1'b1;
                    if (fbit_in) begin
                        // New frame mid-word: restart capture on this bit.
                        start     = 1'b1;
                        frame_bad = 1'b1;
                    end else if (bit_cnt == BIT_W'(N - 1)) begin
                        state_next = ST_ACC;
                    end
                end
                ST_ACC: begin
                    acc_en = 1'b1;
                    if (fbit_in) begin
                        // Back-to-back word: capture its bit 0 now, skip ST_DONE.
                        shift_en   = 1'b1;
                        start      = 1'b1;
                        state_next = ST_SHIFT;
                    end else begin
                        state_next = last_word ? ST_DONE : ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Deserializer, accumulator and result registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            acc       <= '0;
            word_cnt  <= '0;
            sum       <= '0;
            sum_sat   <= '0;
            sat_flag  <= 1'b0;
            sum_valid <= 1'b0;
            frm_err   <= 1'b0;
        end else begin
            sum_valid <= 1'b0;
            if (clear) begin
                bit_cnt  <= '0;
                acc      <= '0;
                word_cnt <= '0;
                frm_err  <= 1'b0;
            end else begin
                if (shift_en) begin
                    shreg   <= {y_in, shreg[N-1:1]};
                    bit_cnt <= start ? BIT_W'(1) : bit_cnt + BIT_W'(1);
                end
                if (frame_bad)
                    frm_err <= 1'b1;
                if (acc_en) begin
                    if (last_word) begin
                        sum       <= acc_sum;
                        sum_sat   <= sat_word(acc_sum);
                        sat_flag  <= sat_hit(acc_sum);
                        sum_valid <= 1'b1;
                        acc       <= '0;
                        word_cnt  <= '0;
                    end else begin
                        acc      <= acc_sum;
                        word_cnt <= word_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rbf_layer_accum_serial.sv
// Randomized bench for rbf_layer_accum_serial (N=16, M=4): words are sent
// serially, a queue-based model computes each pass sum with plain integer
// arithmetic, and a monitor matches every sum_valid pulse against it.
module tb_rbf_layer_accum_serial;

    localparam int N     = 16;
    localparam int M     = 4;
    localparam int ACC_W = 19;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             y_in;
    logic             fbit_in;
    logic [ACC_W-1:0] sum;
    logic [N-1:0]     sum_sat;
    logic             sum_valid;
    logic             sat_flag;
    logic             busy;
    logic             frm_err;

    rbf_layer_accum_serial #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .y_in      (y_in),
        .fbit_in   (fbit_in),
        .sum       (sum),
        .sum_sat   (sum_sat),
        .sum_valid (sum_valid),
        .sat_flag  (sat_flag),
        .busy      (busy),
        .frm_err   (frm_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: words of the current pass, and expected results.
    typedef struct {
        logic [ACC_W-1:0] s;
        logic [N-1:0]     ss;
        logic             f;
        int               c;
    } exp_t;

    logic [N-1:0]     pass_q[$];
    exp_t             exp_q[$];
    logic [ACC_W-1:0] last_exp_sum = '0;

    task automatic model_word(input logic [N-1:0] w, input int fcyc);
        longint      total;
        logic [63:0] bits;
        exp_t        e;
        pass_q.push_back(w);
        if (pass_q.size() == M) begin
            total = 0;
            foreach (pass_q[i]) total += longint'($signed(pass_q[i]));
            bits = total;
            e.s  = bits[ACC_W-1:0];
            if (total > 32767) begin
                e.ss = 16'h7FFF;
                e.f  = 1'b1;
            end else if (total < -32768) begin
                e.ss = 16'h8000;
                e.f  = 1'b1;
            end else begin
                e.ss = bits[N-1:0];
                e.f  = 1'b0;
            end
            // fbit of the last word seen at cycle c -> valid visible N+1 cycles later
            e.c = fcyc + N + 1;
            exp_q.push_back(e);
            pass_q.delete();
        end
    endtask

    // Monitor: every valid pulse must match the next expected result.
    always @(negedge clk) begin
        exp_t e;
        if (rst && sum_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                last_exp_sum = e.s;
                check("sum", sum, e.s);
                check("sum_sat", sum_sat, e.ss);
                check("sat_flag", sat_flag, e.f);
                check("valid_cycle", cyc, e.c);
            end
        end
    end

    // Send one word LSB first; cut >= 0 stops after that many bits.
    task automatic send_word(input logic [N-1:0] w, input int gap, input int cut);
        int fc = 0;
        int nb = (cut < 0) ? N : cut;
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            if (i == 0) fc = cyc;
            y_in    = w[i];
            fbit_in = (i == 0);
        end
        if (cut < 0) model_word(w, fc);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            y_in    = 1'($urandom_range(0, 1));
            fbit_in = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            y_in    = 1'($urandom_range(0, 1));
            fbit_in = 1'b0;
        end
    endtask

    function automatic logic [N-1:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            default: return 16'($urandom());
        endcase
    endfunction

    initial begin
        rst     = 1'b0;
        clear   = 1'b0;
        y_in    = 1'b0;
        fbit_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sum", sum, 0);
        check("rst_sum_sat", sum_sat, 0);
        check("rst_sum_valid", sum_valid, 0);
        check("rst_sat_flag", sat_flag, 0);
        check("rst_busy", busy, 0);
        check("rst_frm_err", frm_err, 0);
        rst = 1'b1;
        idle(2);

        // Mixed-sign words with gaps: 0x2800, no saturation.
        send_word(16'h1000, 3, -1);
        send_word(16'h2000, 3, -1);
        check("busy_mid_pass", busy, 1);
        send_word(16'hF000, 3, -1);
        send_word(16'h0800, 3, -1);
        idle(4);
        check("busy_after_pass", busy, 0);
        check("sum_2800", sum, 19'h02800);

        // Positive overflow, back-to-back.
        for (int i = 0; i < 4; i++) send_word(16'h4000, 0, -1);
        idle(4);
        check("sum_pos_sat", sum, 19'h10000);

        // Negative overflow.
        for (int i = 0; i < 4; i++) send_word(16'hC000, 0, -1);
        idle(4);
        check("sum_neg_sat", sum_sat, 16'h8000);

        // Framing error: second word interrupted at bit 7.
        send_word(16'h1234, 2, -1);
        send_word(16'h7777, 0, 7);
        send_word(16'h0101, 1, -1);
        send_word(16'hFFFE, 0, -1);
        send_word(16'h0040, 2, -1);
        idle(4);
        check("frm_err_set", frm_err, 1);
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        check("frm_err_cleared", frm_err, 0);

        // Reset during word 3 of a pass.
        send_word(16'h3000, 1, -1);
        send_word(16'h0123, 1, -1);
        send_word(16'h5555, 0, 9);
        @(negedge clk); rst = 1'b0; fbit_in = 1'b0;
        pass_q.delete();
        @(negedge clk);
        check("rstmid_sum", sum, 0);
        check("rstmid_sum_sat", sum_sat, 0);
        check("rstmid_sat_flag", sat_flag, 0);
        check("rstmid_busy", busy, 0);
        rst = 1'b1;
        idle(2);
        for (int i = 0; i < 4; i++) send_word(rand_word(), 1, -1);
        idle(4);

        // Clear mid-pass drops the partial sum but keeps the last result.
        send_word(16'h0F00, 1, -1);
        send_word(16'h00F0, 0, 5);
        @(negedge clk); clear = 1'b1; fbit_in = 1'b0;
        pass_q.delete();
        @(negedge clk); clear = 1'b0;
        check("clear_keeps_sum", sum, last_exp_sum);
        check("clear_busy", busy, 0);
        for (int i = 0; i < 4; i++) send_word(rand_word(), 0, -1);
        idle(4);

        // Two passes back-to-back.
        for (int i = 0; i < 2 * M; i++) send_word(rand_word(), 0, -1);
        idle(4);

        // Random words and gaps.
        for (int i = 0; i < 40; i++) send_word(rand_word(), $urandom_range(0, 3), -1);
        idle(20);
        check("all_results_seen", exp_q.size(), 0);
        check("busy_end", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
